// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op encodings, FSM states, default width.
// Also imported by the decoder and the hazard unit.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply (shift-add) or restoring divide (shift-subtract).
// Purely combinational; the sequencer registers the result once per CALC cycle.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
    diff    = shifted[WIDTH-1:0] - opnd;
    ge      = (shifted >= {1'b0, opnd});
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      hi_next = ge ? diff : shifted[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply-divide sequencer: FSM, iteration counter, sign fix-up and result registers.
//   state | meaning
//   IDLE  | waiting for an accepted op
//   CALC  | one shift-add/subtract step per cycle on operand magnitudes
//   FIX   | sign correction; HI/LO written when leaving
//   DONE  | one-cycle completion pulse
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = MULDIV_WIDTH,
  parameter int CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);

  state_e state_q, state_d;
  op_e    op_in;
  logic   accept, is_div_in, is_signed_in, rs_neg, rt_neg, div_zero;
  logic   is_div_q, neg_q, rem_neg_q, dz_q;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH-1:0]   opnd_q, acc_hi_q, acc_lo_q, step_hi, step_lo;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt_q;

  assign op_in        = op_e'(op);
  assign is_div_in    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign is_signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign rs_neg       = is_signed_in & rs_val[WIDTH-1];
  assign rt_neg       = is_signed_in & rt_val[WIDTH-1];
  assign rs_mag       = rs_neg ? -rs_val : rs_val;
  assign rt_mag       = rt_neg ? -rt_val : rt_val;
  assign div_zero     = is_div_in && (rt_val == '0);
  assign accept       = start & ~flush & (state_q == ST_IDLE);

  assign busy  = (state_q != ST_IDLE);
  assign stall = busy & (start | rd_req);
  assign done  = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = div_zero ? ST_FIX : ST_CALC;
      ST_CALC: begin
        if (flush)               state_d = ST_IDLE;
        else if (cnt_q == '0)    state_d = ST_FIX;
      end
      ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .opnd    (opnd_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Divide-by-zero results are preloaded raw and bypass the sign fix.
  always_comb begin
    prod   = {acc_hi_q, acc_lo_q};
    fix_hi = acc_hi_q;
    fix_lo = acc_lo_q;
    if (!dz_q) begin
      if (!is_div_q) begin
        if (neg_q) prod = -prod;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
      end else begin
        if (neg_q)     fix_lo = -acc_lo_q;
        if (rem_neg_q) fix_hi = -acc_hi_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      if (accept) begin
        is_div_q  <= is_div_in;
        neg_q     <= rs_neg ^ rt_neg;
        rem_neg_q <= rs_neg;
        dz_q      <= div_zero;
        opnd_q    <= is_div_in ? rt_mag : rs_mag;
        cnt_q     <= CNT_LOAD;
        if (div_zero) begin
          acc_hi_q <= rs_val;
          acc_lo_q <= '1;
        end else begin
          acc_hi_q <= '0;
          acc_lo_q <= is_div_in ? rs_mag : rt_mag;
        end
      end else if (state_q == ST_CALC) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == ST_FIX && !flush) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed results and cycle counts.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rd_req, flush;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic [31:0] hi, lo;
  logic        busy, stall, done;
  int          passed = 0;
  int          total  = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .rd_req (rd_req),
    .flush  (flush),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accept edge; returns 100 if done never rises.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rd_req = 1'b0; flush = 1'b0;
    op = 2'b00; rs_val = '0; rt_val = '0;
    #2;
    total++; if (busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", busy);   else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
    total++; if (done !== 1'b0)  $display("FAIL reset_done: got %b want 0", done);   else passed++;
    total++; if (hi !== 32'h0)   $display("FAIL reset_hi: got %h want 0", hi);       else passed++;
    total++; if (lo !== 32'h0)   $display("FAIL reset_lo: got %h want 0", lo);       else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int cyc;
    start_op(MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_done(cyc);
    total++; if (cyc !== 34)          $display("FAIL multu_cycle: got %0d want 34", cyc);  else passed++;
    total++; if (hi !== 32'h0000_0001) $display("FAIL multu_hi: got %h want 00000001", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h want fffffffe", lo); else passed++;
    @(posedge clk); #1;
    total++; if ({done, busy} !== 2'b00) $display("FAIL multu_pulse: got done=%b busy=%b want 0 0", done, busy); else passed++;
  endtask

  task automatic test_signed();
    int cyc;
    start_op(MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(cyc);
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi: got %h want ffffffff", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_neg_lo: got %h want fffffff1", lo); else passed++;
    start_op(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo: got %h want fffffffd", lo); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi: got %h want ffffffff", hi); else passed++;
    start_op(DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc);
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_negdiv_lo: got %h want fffffffd", lo); else passed++;
    total++; if (hi !== 32'h0000_0001) $display("FAIL div_negdiv_hi: got %h want 00000001", hi); else passed++;
    start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    total++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h want 80000000", lo); else passed++;
    total++; if (hi !== 32'h0)         $display("FAIL div_ovf_hi: got %h want 00000000", hi); else passed++;
  endtask

  task automatic test_div_zero();
    int cyc;
    start_op(DIVU, 32'd10, 32'd0);
    wait_done(cyc);
    total++; if (cyc !== 2)             $display("FAIL divz_cycle: got %0d want 2", cyc);     else passed++;
    total++; if (lo !== 32'hFFFF_FFFF)  $display("FAIL divz_lo: got %h want ffffffff", lo);  else passed++;
    total++; if (hi !== 32'h0000_000A)  $display("FAIL divz_hi: got %h want 0000000a", hi);  else passed++;
    start_op(DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(cyc);
    total++; if (lo !== 32'hFFFF_FFFF)  $display("FAIL divz_s_lo: got %h want ffffffff", lo); else passed++;
    total++; if (hi !== 32'hFFFF_FFFB)  $display("FAIL divz_s_hi: got %h want fffffffb", hi); else passed++;
  endtask

  task automatic test_back_to_back();
    int n, d1, d2, bad;
    start_op(MULTU, 32'd6, 32'd7);
    start = 1'b1; rd_req = 1'b1; op = MULTU; rs_val = 32'd5; rt_val = 32'd9;
    n = 1; d1 = 0; bad = 0;
    while (busy && n < 100) begin
      if (stall !== 1'b1) bad++;
      if (done) begin
        d1 = n;
        total++; if (lo !== 32'd42) $display("FAIL b2b_first_lo: got %0d want 42", lo); else passed++;
      end
      @(posedge clk); #1; n++;
    end
    total++; if (bad !== 0) $display("FAIL b2b_stall: got %0d non-stall busy cycles want 0", bad); else passed++;
    total++; if (d1 !== 34) $display("FAIL b2b_first_cycle: got %0d want 34", d1);              else passed++;
    @(posedge clk); #1;
    start = 1'b0; rd_req = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", busy); else passed++;
    wait_done(d2);
    total++; if (d2 !== 34)     $display("FAIL b2b_second_cycle: got %0d want 34", d2); else passed++;
    total++; if (lo !== 32'd45) $display("FAIL b2b_second_lo: got %0d want 45", lo);    else passed++;
  endtask

  task automatic test_flush();
    int cyc, dones;
    start_op(MULTU, 32'h8000_0001, 32'd2);
    wait_done(cyc);
    start_op(MULTU, 32'd3, 32'd3);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else passed++;
    total++; if (hi !== 32'h1)  $display("FAIL flush_hi: got %h want 1", hi);     else passed++;
    total++; if (lo !== 32'h2)  $display("FAIL flush_lo: got %h want 2", lo);     else passed++;
    dones = 0;
    repeat (40) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    total++; if (dones !== 0) $display("FAIL flush_no_done: got %0d done cycles want 0", dones); else passed++;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MULTU; rs_val = 32'd2; rt_val = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL flush_priority: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_op(MULTU, 32'd7, 32'd9);
    rd_req = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    total++; if (stall !== 1'b1) $display("FAIL rstmid_pre_stall: got %b want 1", stall); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)  $display("FAIL rstmid_busy: got %b want 0", busy);   else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", stall); else passed++;
    total++; if (done !== 1'b0)  $display("FAIL rstmid_done: got %b want 0", done);   else passed++;
    total++; if ({hi, lo} !== 64'h0) $display("FAIL rstmid_hilo: got %h %h want 0 0", hi, lo); else passed++;
    rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; op = MULTU; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL rstmid_accept: got busy=%b want 1", busy); else passed++;
    wait_done(cyc);
    total++; if (cyc !== 34)    $display("FAIL rstmid_cycle: got %0d want 34", cyc); else passed++;
    total++; if (lo !== 32'd12) $display("FAIL rstmid_lo: got %0d want 12", lo);     else passed++;
    total++; if (hi !== 32'd0)  $display("FAIL rstmid_hi: got %0d want 0", hi);      else passed++;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand, HI and LO width.
REQ-002 SHALL have parameter CYCLES, default WIDTH, meaning the number of iteration steps in CALC.
REQ-003 SHALL have port clk  input  1  the single pipeline clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  EX stage presents a mul/div op this cycle.
REQ-006 SHALL have port op  input  2  op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port rs_val  input  WIDTH  multiplicand or dividend.
REQ-008 SHALL have port rt_val  input  WIDTH  multiplier or divisor.
REQ-009 SHALL have port rd_req  input  1  an MFHI/MFLO is in EX this cycle.
REQ-010 SHALL have port flush  input  1  pipeline flush; cancels any in-flight op.
REQ-011 SHALL have port hi  output  WIDTH  HI register (product high word / remainder).
REQ-012 SHALL have port lo  output  WIDTH  LO register (product low word / quotient).
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.
REQ-014 SHALL have port stall  output  1  freeze request to the pipeline.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-017 SHALL accept an op only when start=1, flush=0 and state=IDLE, latching op and both operands and entering CALC.
REQ-018 SHALL, in CALC, perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes, then enter FIX after exactly CYCLES cycles.
REQ-019 SHALL, for signed ops, take magnitudes on accept; FIX negates the product, or the quotient, when the operand signs differ, and gives the remainder the sign of the dividend.
REQ-020 SHALL, for DIV/DIVU with rt_val=0, skip CALC (IDLE->FIX) and write lo=all-ones, hi=rs_val.
REQ-021 SHALL handle DIV 0x80000000 / 0xFFFFFFFF with the same magnitude path, giving lo=0x80000000, hi=0 without error.
REQ-022 SHALL write hi and lo only on the FIX->DONE edge; they hold their value at all other times.
REQ-023 SHALL assert done only in state DONE (exactly one cycle); with WIDTH=32, done appears in cycle 34 after the accept edge, or cycle 2 for divide-by-zero.
REQ-024 SHALL drive busy = (state != IDLE) and stall = busy & (start | rd_req), both combinational.
REQ-025 SHALL ignore a start arriving while busy; the pipeline holds it under stall, and it is accepted in the first IDLE cycle.
REQ-026 SHALL, on flush in CALC or FIX, return to IDLE on the next edge with hi/lo unchanged and no done.
REQ-027 SHALL give flush priority over start when both are asserted in IDLE (no accept).
REQ-028 SHALL ignore flush in DONE, because the result is already committed.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=IDLE, hi=0, lo=0, done=0, busy=0, stall=0, and clear the internal accumulator and counter.
REQ-030 SHALL, if reset occurs mid-op, discard the op; after release the block accepts a new start on the first rising edge.

Structure
REQ-031 SHALL place the op encodings, the FSM state enum and the WIDTH default in a shared package muldiv_pkg, also used by the decoder and hazard unit.
REQ-032 SHALL put the per-iteration datapath (one add/subtract-and-shift step) in a sub-module muldiv_step; muldiv_sequencer owns the FSM, counter, sign fix and HI/LO.

Verification
REQ-033 SHALL cover: MULTU 0xFFFFFFFF x 2 -> done in cycle 34, hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 SHALL cover: MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 SHALL cover: DIVU 10 / 0 -> done in cycle 2, lo=0xFFFFFFFF, hi=0x0000000A.
REQ-036 SHALL cover: second start and rd_req during CALC -> stall=1 every busy cycle; second op accepted the cycle after done; its result appears 34 cycles later.
REQ-037 SHALL cover: flush in CALC cycle 10 after a prior result hi=1, lo=2 -> IDLE next edge, no done, hi=1, lo=2 retained.
REQ-038 SHALL cover: rst_n low mid-CALC (asynchronous, between edges) -> busy, stall and done drop at once, hi=lo=0; a new MULTU 3 x 4 after release gives lo=12.
